circular_shift_serial_rotator: RTL
==================================

Name: circular_shift_serial_rotator

Overview:
- Sequential circular shifter with run-time shift amount and direction; rotates one bit position per clock.
- Counterpart to the fixed-amount combinational left/right rotators: the amount and direction are dynamic, and the block trades latency for area.
- Valid/ready handshake on input and output. Sits between a producer and a consumer stage in arithmetic/pipelining exercises.

Parameters:
- N, 8, data width in bits; must be a power of 2 and at least 2.
- W, $clog2(N), width of the shift-amount field; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  producer offers an operation.
- in_ready  output  1  block can accept an operation.
- in_data  input  N  word to rotate.
- in_amt  input  W  rotation amount, 0..N-1.
- in_dir  input  1  0 = rotate left (toward MSB), 1 = rotate right (toward LSB).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_data  output  N  rotated word.

Behaviour:
- Reset (async, active-high): state = IDLE, data register = 0, count = 0, direction = 0. Therefore out_valid = 0, out_data = 0, in_ready = 1 (decoded from IDLE).
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Accept: when in_valid && in_ready at a rising edge, the block captures in_data, in_amt and in_dir.
  - If in_amt == 0, next state = DONE.
  - Otherwise, next state = SHIFT and count = in_amt.
- SHIFT, on each edge:
  - The data register rotates by exactly 1 in the captured direction: left = {d[N-2:0], d[N-1]}, right = {d[0], d[N-1:1]}.
  - count decrements. When count == 1 on that edge, next state = DONE.
- Latency: if the handshake occurs in cycle c, out_valid is first high in cycle c+1+amt. Exactly amt single-bit rotations are applied.
- DONE: out_valid is held high and out_data is held stable until out_valid && out_ready at an edge; next state = IDLE.
  - The input is not accepted in DONE or SHIFT.
  - Minimum spacing between accepted operations is amt+2 cycles.
- Inputs are ignored outside the accept edge. Changes to in_data, in_amt or in_dir during SHIFT or DONE have no effect.
- Backpressure: out_ready low in DONE keeps the state in DONE indefinitely; out_data does not change.
- out_ready high outside DONE has no effect.
- Rotation wraps modulo N. amt = N-1 left is equivalent to a 1-bit right rotation; the block still spends N-1 cycles.
- Reset asserted mid-SHIFT or mid-DONE aborts immediately to reset values. The in-flight result is discarded and no out_valid pulse occurs.
- out_data is the data register, which is only meaningful while out_valid is high. In IDLE it holds the last delivered result.

Test Plan:
- Left rotate: in_data=10110101, amt=3, dir=0, accept in cycle c -> out_valid first high in cycle c+4, out_data=10101101.
- Right rotate: in_data=10110101, amt=3, dir=1 -> out_data=10110110, latency 4. Also 00000001, amt=7, dir=1 -> 00000010; and 00000001, amt=7, dir=0 -> 10000000 with out_valid in cycle c+8.
- Zero amount: in_data=01100110, amt=0 -> out_valid in cycle c+1, out_data=01100110; in_ready low for exactly 1 cycle when out_ready is held high.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and out_data is constant. in_valid=1 with different data during that time is not accepted (in_ready=0). Raising out_ready -> one transfer, then in_ready=1 next cycle.
- Reset mid-operation: accept 11100000, amt=5, assert rst 2 cycles later -> out_valid=0, out_data=0, in_ready=1 immediately (async). After release, a new operation 11100000, amt=3, dir=0 yields 00000111.
- Random stream of 200 operations with random in_valid/out_ready gating, checked against a reference model ((a<<s)|(a>>(N-s)) for left, mirrored for right) -> every accepted operation produces exactly one matching result in order. No duplicates and no drops.

Source files
------------

// File: rtl/circular_shift_serial_rotator.sv
// Serial circular shifter: rotates a captured word one bit per clock, by a
// run-time amount and direction, with valid/ready handshakes on both sides.
module circular_shift_serial_rotator #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] in_amt,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] data_q, data_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         dir_q, dir_d;

  // State, data, remaining-count and direction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic: capture on accept, rotate by one per SHIFT cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          dir_d   = in_dir;
          cnt_d   = in_amt;
          state_d = (in_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = dir_q ? {data_q[0], data_q[N-1:1]}
                       : {data_q[N-2:0], data_q[N-1]};
        cnt_d  = cnt_q - W'(1);
        if (cnt_q == W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake flags are decoded from registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;

endmodule
